// File: rtl/ddr_tx_sched.sv
// Round-robin scheduler for two word sources sharing one DDR output lane.
// Each accepted word is sent MSB first, one bit pair (D0/D1) per clock.
//
// state | meaning
// IDLE  | lane quiet (ce low, zeros held); window open
// SHIFT | presenting beats of a word; window opens on the last beat
// FLUSH | one zero pair with ce high, then IDLE
module ddr_tx_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ddr_d0,
  output logic             ddr_d1,
  output logic             ddr_ce,
  output logic             ddr_r,
  output logic             busy,
  output logic             grant_id,
  output logic             frame_start
);

  localparam int BEATS = WIDTH / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
  logic             ddr_d0_q, ddr_d0_d;
  logic             ddr_d1_q, ddr_d1_d;
  logic             ddr_ce_q, ddr_ce_d;
  logic             ddr_r_q, ddr_r_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;

  logic             last_beat, window_open, gnt0, gnt1, xfer;
  logic [WIDTH-1:0] word;

  assign last_beat   = (state_q == SHIFT) && (beat_cnt_q == CW'(BEATS - 1));
  // Ready must stay low while reset is held, even though state reads IDLE.
  assign window_open = !reset && ((state_q == IDLE) || last_beat);
  assign gnt0        = req0_valid && (!req1_valid || last_grant_q);
  assign gnt1        = req1_valid && (!req0_valid || !last_grant_q);
  assign req0_ready  = window_open && gnt0;
  assign req1_ready  = window_open && gnt1;
  assign xfer        = req0_ready || req1_ready;
  assign word        = req1_ready ? req1_data : req0_data;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    beat_cnt_d    = beat_cnt_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    ddr_d0_d      = 1'b0;
    ddr_d1_d      = 1'b0;
    ddr_ce_d      = 1'b0;
    ddr_r_d       = 1'b0;
    frame_start_d = 1'b0;
    if (xfer) begin
      state_d       = SHIFT;
      shift_d       = word << 2;
      beat_cnt_d    = '0;
      last_grant_d  = req1_ready;
      grant_id_d    = req1_ready;
      ddr_d0_d      = word[WIDTH-1];
      ddr_d1_d      = word[WIDTH-2];
      ddr_ce_d      = 1'b1;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          ddr_ce_d = 1'b1;
          if (last_beat) begin
            state_d = FLUSH;
          end else begin
            ddr_d0_d   = shift_q[WIDTH-1];
            ddr_d1_d   = shift_q[WIDTH-2];
            shift_d    = shift_q << 2;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        FLUSH:   state_d = IDLE;
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      beat_cnt_q    <= '0;
      last_grant_q  <= 1'b1;
      grant_id_q    <= 1'b0;
      ddr_d0_q      <= 1'b0;
      ddr_d1_q      <= 1'b0;
      ddr_ce_q      <= 1'b0;
      ddr_r_q       <= 1'b1;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      beat_cnt_q    <= beat_cnt_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      ddr_d0_q      <= ddr_d0_d;
      ddr_d1_q      <= ddr_d1_d;
      ddr_ce_q      <= ddr_ce_d;
      ddr_r_q       <= ddr_r_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign ddr_d0      = ddr_d0_q;
  assign ddr_d1      = ddr_d1_q;
  assign ddr_ce      = ddr_ce_q;
  assign ddr_r       = ddr_r_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ddr_tx_sched.sv
// Bench for ddr_tx_sched: a queue-of-beats lane model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_ddr_tx_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready;
  logic         ddr_d0, ddr_d1, ddr_ce, ddr_r, busy, grant_id, frame_start;

  int n_vec = 0;
  int n_err = 0;

  ddr_tx_sched #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .ddr_d0(ddr_d0), .ddr_d1(ddr_d1), .ddr_ce(ddr_ce), .ddr_r(ddr_r),
    .busy(busy), .grant_id(grant_id), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the lane shows this cycle, plus beats already committed for later cycles.
  typedef struct packed {
    logic d0, d1, ce, fs, bsy, gid, dat;
  } beat_t;

  beat_t  m_q[$];
  beat_t  cur = '0;
  logic   m_last = 1'b1;
  logic   r_exp = 1'b1;
  logic   open, e0, e1, src;
  logic [W-1:0] wd;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_d0", ddr_d0, 0);  chk("rst_d1", ddr_d1, 0);
      chk("rst_ce", ddr_ce, 0);  chk("rst_r", ddr_r, 1);
      chk("rst_busy", busy, 0);  chk("rst_gid", grant_id, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_rdy0", req0_ready, 0); chk("rst_rdy1", req1_ready, 0);
      m_q.delete();
      cur    = '0;
      m_last = 1'b1;
      r_exp  = 1'b1;
    end else begin
      chk("d0", ddr_d0, cur.d0);   chk("d1", ddr_d1, cur.d1);
      chk("ce", ddr_ce, cur.ce);   chk("fs", frame_start, cur.fs);
      chk("busy", busy, cur.bsy);  chk("gid", grant_id, cur.gid);
      chk("ddr_r", ddr_r, r_exp);
      open = !cur.ce || (cur.dat && m_q.size() == 0);
      e0 = open && req0_valid && (!req1_valid || m_last);
      e1 = open && req1_valid && (!req0_valid || !m_last);
      chk("rdy0", req0_ready, e0);
      chk("rdy1", req1_ready, e1);
      if (e0 || e1) begin
        src    = e1;
        m_last = src;
        wd     = src ? req1_data : req0_data;
        for (int k = 0; k < W / 2; k++)
          m_q.push_back('{d0: wd[W-1-2*k], d1: wd[W-2-2*k], ce: 1'b1, fs: (k == 0),
                          bsy: 1'b1, gid: src, dat: 1'b1});
      end else if (cur.dat && m_q.size() == 0) begin
        m_q.push_back('{d0: 1'b0, d1: 1'b0, ce: 1'b1, fs: 1'b0, bsy: 1'b1, gid: cur.gid, dat: 1'b0});
      end
      r_exp = 1'b0;
      if (m_q.size() > 0) cur = m_q.pop_front();
      else cur = '{d0: 1'b0, d1: 1'b0, ce: 1'b0, fs: 1'b0, bsy: 1'b0, gid: cur.gid, dat: 1'b0};
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic [1:0] pairs_b4 [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  int         order [6];
  int         at_cyc [6];
  logic       a0, a1;

  initial begin
    int n, sent0, sent1, cnum, dens;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Single word 8'hB4 from requester 0.
    cyc();
    req0_valid = 1'b1; req0_data = 8'hB4;
    @(negedge clk); chk("b4_rdy0", req0_ready, 1);
    cyc(); req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b4_pair", {ddr_d0, ddr_d1}, pairs_b4[k]);
      chk("b4_ce", ddr_ce, 1);
      chk("b4_fs", frame_start, (k == 0));
      chk("b4_gid", grant_id, 0);
    end
    @(negedge clk); chk("b4_flush", {ddr_ce, ddr_d0, ddr_d1}, 3'b100);
    @(negedge clk); chk("b4_idle_ce", ddr_ce, 0);
    repeat (2) cyc();

    // Tie after reset: requester 0 wins, requester 1 follows with no gap.
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    req0_valid = 1'b1; req0_data = 8'hFF;
    req1_valid = 1'b1; req1_data = 8'h00;
    @(negedge clk); chk("tie_rdy0", req0_ready, 1); chk("tie_rdy1", req1_ready, 0);
    cyc(); req0_valid = 1'b0;
    @(negedge clk); chk("tie_gid0", grant_id, 0); chk("tie_fs0", frame_start, 1);
    repeat (3) @(negedge clk);
    chk("tie_rdy1_last", req1_ready, 1);
    chk("tie_beat3", {ddr_d0, ddr_d1}, 2'b11);
    cyc(); req1_valid = 1'b0;
    @(negedge clk); chk("tie_gid1", grant_id, 1); chk("tie_fs1", frame_start, 1);
    chk("tie_b1", {ddr_ce, ddr_d0, ddr_d1}, 3'b100);
    repeat (6) cyc();

    // Fairness: both hold valid for three words each.
    n = 0; sent0 = 0; sent1 = 0; cnum = 0;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    while (n < 6 && cnum < 100) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      if (a0) begin order[n] = 0; at_cyc[n] = cnum; n++; end
      if (a1) begin order[n] = 1; at_cyc[n] = cnum; n++; end
      cyc(); cnum++;
      if (a0) begin sent0++; req0_data = W'($urandom); if (sent0 == 3) req0_valid = 1'b0; end
      if (a1) begin sent1++; req1_data = W'($urandom); if (sent1 == 3) req1_valid = 1'b0; end
    end
    chk("fair_count", n, 6);
    if (n == 6) begin
      for (int i = 0; i < 6; i++) chk("fair_order", order[i], i % 2);
      chk("fair_span", at_cyc[5] - at_cyc[0], 20);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) cyc();

    // FLUSH boundary: valid raised during FLUSH waits for IDLE.
    req0_valid = 1'b1; req0_data = 8'h5A;
    cyc(); req0_valid = 1'b0;
    repeat (4) cyc();
    req1_valid = 1'b1; req1_data = 8'h96;
    @(negedge clk);
    chk("fl_state", {ddr_ce, ddr_d0, ddr_d1, busy}, 4'b1001);
    chk("fl_rdy1", req1_ready, 0);
    cyc();
    @(negedge clk); chk("fl_idle_ce", ddr_ce, 0); chk("fl_idle_rdy1", req1_ready, 1);
    cyc(); req1_valid = 1'b0;
    @(negedge clk); chk("fl_fs", frame_start, 1); chk("fl_gid", grant_id, 1);
    chk("fl_b0", {ddr_d0, ddr_d1}, 2'b10);
    repeat (6) cyc();

    // Reset during beat 2 of 8'hA5.
    req0_valid = 1'b1; req0_data = 8'hA5;
    cyc(); req0_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1; req0_valid = 1'b1; req0_data = 8'h3C;
    #1;
    chk("mid_async", {ddr_d0, ddr_d1, ddr_ce, ddr_r, busy, grant_id, frame_start}, 7'b0001000);
    chk("mid_rdy0", req0_ready, 0);
    @(posedge clk); #2 reset = 1'b0;
    req1_valid = 1'b1; req1_data = 8'hC3;
    @(negedge clk); chk("mid_rdy0_win", req0_ready, 1); chk("mid_rdy1", req1_ready, 0);
    chk("mid_idle", {ddr_ce, busy}, 2'b00);
    cyc(); req0_valid = 1'b0;
    @(negedge clk); chk("mid_new_b0", {ddr_d0, ddr_d1, frame_start}, 3'b001);
    repeat (3) @(negedge clk);
    chk("mid_rdy1_last", req1_ready, 1);
    cyc(); req1_valid = 1'b0;
    repeat (8) cyc();

    // Randomized traffic with occasional resets.
    dens = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(10, 100);
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      cyc();
      if (reset) begin
        if ($urandom_range(0, 1) == 1) reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
      end
      if (a0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 99) < dens);
        req0_data  = W'($urandom);
      end
      if (a1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 99) < dens);
        req1_data  = W'($urandom);
      end
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (10) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
